// File: rtl/pat_count_pkg.sv
// Shared types and constants for the pattern-count engine.
// Optional crossing-window count is enabled with macro PAT_COUNT_CROSS_EN.
package pat_count_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDPAT,
    S_SCAN,
    S_WR_CTB,
    S_WR_CTO,
    S_WR_CTS,
    S_DONE
  } state_t;

  localparam int DEF_NUM_BYTES = 32;
  localparam int DEF_PAT_ADDR  = 32;
  localparam int DEF_RES_BASE  = 33;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/pat_match4.sv
// Counts how many of the four 5-bit windows [4:0], [5:1], [6:2], [7:3]
// of an 8-bit field equal the 5-bit pattern (result 0..4).
module pat_match4 (
  input  logic [7:0] field,
  input  logic [4:0] pat,
  output logic [2:0] count
);

  assign count = 3'(field[4:0] == pat) + 3'(field[5:1] == pat) +
                 3'(field[6:2] == pat) + 3'(field[7:3] == pat);

endmodule

// File: rtl/pat_count_engine.sv
// Pattern-count engine: loads a 5-bit pattern from data memory, scans the
// string bytes one per cycle, then writes the in-byte window count (ctb),
// the count of bytes with any match (cto) and, when PAT_COUNT_CROSS_EN is
// defined, the bitstream window count including byte crossings (cts).
// Without PAT_COUNT_CROSS_EN the cts logic and its write state are absent.
module pat_count_engine
  import pat_count_pkg::*;
#(
  parameter int NUM_BYTES = DEF_NUM_BYTES,
  parameter int PAT_ADDR  = DEF_PAT_ADDR,
  parameter int RES_BASE  = DEF_RES_BASE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  state_t           state, next_state;
  logic [4:0]       pat;
  logic [7:0]       idx;
  logic [CNT_W-1:0] ctb, cto;
  logic [2:0]       in_cnt;

  pat_match4 u_in_match (
    .field (mem_rd_data),
    .pat   (pat),
    .count (in_cnt)
  );

`ifdef PAT_COUNT_CROSS_EN
  logic [CNT_W-1:0] cts;
  logic [3:0]       prev_low;
  logic [2:0]       cross_cnt;
  logic [2:0]       cross_eff;

  pat_match4 u_cross_match (
    .field ({prev_low, mem_rd_data[7:4]}),
    .pat   (pat),
    .count (cross_cnt)
  );

  // Byte 0 has no predecessor, so its crossing windows do not exist.
  assign cross_eff = (idx == 8'd0) ? 3'd0 : cross_cnt;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state sequencing; req only matters when idle or finished.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (req) next_state = S_LDPAT;
      S_LDPAT:        next_state = S_SCAN;
      S_SCAN:         if (idx == LAST_IDX) next_state = S_WR_CTB;
      S_WR_CTB:       next_state = S_WR_CTO;
`ifdef PAT_COUNT_CROSS_EN
      S_WR_CTO:       next_state = S_WR_CTS;
      S_WR_CTS:       next_state = S_DONE;
`else
      S_WR_CTO:       next_state = S_DONE;
`endif
      default:        next_state = S_IDLE;
    endcase
  end

  // Datapath: clear on run start, latch pattern, accumulate while scanning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat <= '0;
      idx <= '0;
      ctb <= '0;
      cto <= '0;
`ifdef PAT_COUNT_CROSS_EN
      cts      <= '0;
      prev_low <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (req) begin
            idx <= '0;
            ctb <= '0;
            cto <= '0;
`ifdef PAT_COUNT_CROSS_EN
            cts      <= '0;
            prev_low <= '0;
`endif
          end
        end
        S_LDPAT: begin
          pat <= mem_rd_data[7:3];
          idx <= '0;
        end
        S_SCAN: begin
          ctb <= ctb + CNT_W'(in_cnt);
          if (in_cnt != 3'd0) cto <= cto + CNT_W'(1);
`ifdef PAT_COUNT_CROSS_EN
          cts      <= cts + CNT_W'(in_cnt) + CNT_W'(cross_eff);
          prev_low <= mem_rd_data[3:0];
`endif
          idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory interface and status outputs decoded from the current state.
  always_comb begin
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    done        = 1'b0;
    case (state)
      S_LDPAT: mem_addr = 8'(PAT_ADDR);
      S_SCAN:  mem_addr = idx;
      S_WR_CTB: begin
        mem_addr    = 8'(RES_BASE);
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb;
      end
      S_WR_CTO: begin
        mem_addr    = 8'(RES_BASE + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cto;
      end
`ifdef PAT_COUNT_CROSS_EN
      S_WR_CTS: begin
        mem_addr    = 8'(RES_BASE + 2);
        mem_wr_en   = 1'b1;
        mem_wr_data = cts;
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/pat_count_engine.md
PAT_COUNT_ENGINE -- requirements
Module: pat_count_engine

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 32, number of string bytes at data-memory addresses 0..NUM_BYTES-1.
REQ-002 SHALL have parameter PAT_ADDR, default 32, the address of the pattern byte; the pattern is bits [7:3].
REQ-003 SHALL have parameter RES_BASE, default 33, the first of three result addresses.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have port req, input, 1 bit, start request, sampled in IDLE or DONE.
REQ-007 SHALL have port done, output, 1 bit, high while results are complete.
REQ-008 SHALL have port mem_addr, output, 8 bits, data-memory address.
REQ-009 SHALL have port mem_rd_data, input, 8 bits, combinational read data for mem_addr, valid in the same cycle.
REQ-010 SHALL have port mem_wr_en, output, 1 bit, write strobe; memory writes on the next rising edge.
REQ-011 SHALL have port mem_wr_data, output, 8 bits, write data.

Function
REQ-012 SHALL implement the FSM IDLE -> LDPAT -> SCAN -> WR_CTB -> WR_CTO -> WR_CTS -> DONE.
REQ-013 SHALL leave IDLE or DONE for LDPAT on an edge where req=1; in LDPAT it drives mem_addr=PAT_ADDR and latches pat=mem_rd_data[7:3].
REQ-014 SHALL read, in SCAN, byte i at mem_addr=i for i=0..NUM_BYTES-1, one byte per cycle, then go to WR_CTB.
REQ-015 SHALL count ctb, per byte, as the matches of pat against the four windows [4:0], [5:1], [6:2] and [7:3] (0-4 per byte, 8-bit sum, max 128).
REQ-016 SHALL increment cto once for each byte with at least one in-byte match (max 32).
REQ-017 SHALL count cts over the bitstream taken MSB-first with byte 0 most significant:
- byte 0 contributes its 4 in-byte windows.
- each byte i>0 adds the 4 windows of {byte[i-1][3:0], byte[i][7:4]} plus its 4 in-byte windows.
- total 252 windows; the 8-bit count never wraps.
REQ-018 SHALL write one result per state: WR_CTB writes ctb to RES_BASE, WR_CTO writes cto to RES_BASE+1, WR_CTS writes cts to RES_BASE+2, each with mem_wr_en=1 for exactly one cycle; mem_wr_en=0 in all other states.
REQ-019 SHALL give fixed latency: with req sampled at edge k, done rises after edge k+36.
REQ-020 SHALL hold done high in DONE until req is sampled high, which clears done and restarts the run with all counters zeroed.
REQ-021 SHALL ignore req in LDPAT, SCAN and WR_*; req held high through a run yields exactly one run, then an immediate restart from DONE.
REQ-022 SHALL clear all counters on entry to LDPAT; results never carry over between runs.
REQ-023 SHALL drive mem_addr=0 and mem_wr_data=0 in IDLE and DONE.

Reset
REQ-024 SHALL, while reset=0, asynchronously force state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, pat=0 and all counters 0.
REQ-025 SHALL abort a run on reset mid-run with no further memory writes; a subsequent req performs a full correct run.

Configuration
REQ-026 SHALL, with macro PAT_COUNT_CROSS_EN defined, compute cts and include WR_CTS.
REQ-027 SHALL, without PAT_COUNT_CROSS_EN, omit the cts logic and skip WR_CTS (WR_CTO -> DONE):
- address RES_BASE+2 is never written.
- done rises after edge k+35.

Structure
REQ-028 SHALL place in package pat_count_pkg the FSM state enum, the address constant defaults and the counter width constant.
REQ-029 SHALL use one combinational sub-module, pat_match4 (8-bit field and 5-bit pattern in, 3-bit count 0-4 of matches at [4:0], [5:1], [6:2], [7:3] out), instantiated for the in-byte field and, when PAT_COUNT_CROSS_EN is defined, the crossing field.

Verification
REQ-030 SHALL cover: pat=00000, all bytes 0x00 -> [33]=128, [34]=32, [35]=252; done after k+36.
REQ-031 SHALL cover: pat=10101, all bytes 0x55 -> [33]=64, [34]=32, [35]=126.
REQ-032 SHALL cover: pat=11111, byte 5=0xF8, other bytes 0x00 -> 1, 1, 1.
REQ-033 SHALL cover: pat=11111, byte 3=0x03, byte 4=0xE0, other bytes 0x00 -> 0, 0, 1 (crossing only).
REQ-034 SHALL cover: addresses 33-35 preloaded 0xAA, reset pulsed during SCAN byte 10 -> no writes, done=0, 33-35 remain 0xAA; then req -> correct results.
REQ-035 SHALL cover a build without PAT_COUNT_CROSS_EN using the REQ-030 stimulus -> 128 and 32 written, [35] unchanged, done after k+35.
